// File: rtl/rv_pkg.sv
// Shared definitions for the rv_core_sc front end: fetch FSM states,
// datapath defaults and the base opcodes the control unit decodes.
package rv_pkg;

   localparam int          XLEN_DEF     = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } fetch_state_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/rv_fetch.sv
// Instruction fetch stage: owns the PC, runs one imem transaction at a time
// and holds the fetched instruction until the core retires it or redirects.
module rv_fetch
   import rv_pkg::*;
#(
   parameter int               XLEN     = XLEN_DEF,
   parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEF
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   output logic            instr_valid_o,
   input  logic            instr_ready_i,
   output logic [XLEN-1:0] instr_o,
   output logic [6:0]      instr_op_o,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] pc_plus4_o,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            misaligned_o
);

   localparam logic [XLEN-1:0] PC_INC = {{(XLEN-3){1'b0}}, 3'b100};

   fetch_state_e    r_state;
   logic [XLEN-1:0] r_fetch_pc;
   logic            r_kill;
   logic            r_req;
   logic            r_valid;
   logic [XLEN-1:0] r_instr;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_pc_plus4;
   logic            r_misaligned;

   fetch_state_e    w_state_nxt;
   logic [XLEN-1:0] w_fetch_pc_nxt;
   logic            w_kill_nxt;
   logic [XLEN-1:0] w_instr_nxt;
   logic [XLEN-1:0] w_pc_nxt;
   logic            w_misaligned_nxt;

   // Next-state logic; a redirect overrides the fetch PC last so it wins in every state.
   always_comb begin
      w_state_nxt      = r_state;
      w_fetch_pc_nxt   = r_fetch_pc;
      w_kill_nxt       = r_kill;
      w_instr_nxt      = r_instr;
      w_pc_nxt         = r_pc;
      w_misaligned_nxt = r_misaligned;

      case (r_state)
         REQ: begin
            // r_req gates the grant: the first cycle after reset issues no request
            if (r_req && imem_gnt_i) begin
               w_state_nxt = WAIT;
               w_kill_nxt  = redirect_i;
            end else begin
               w_state_nxt = REQ;
            end
         end
         WAIT: begin
            if (imem_rvalid_i) begin
               if (r_kill || redirect_i) begin
                  w_state_nxt = REQ;
                  w_kill_nxt  = 1'b0;
               end else begin
                  w_state_nxt = HOLD;
                  w_instr_nxt = imem_rdata_i;
                  w_pc_nxt    = r_fetch_pc;
               end
            end else if (redirect_i) begin
               w_kill_nxt = 1'b1;
            end else begin
               w_kill_nxt = r_kill;
            end
         end
         HOLD: begin
            if (redirect_i) begin
               w_state_nxt = REQ;
            end else if (instr_ready_i) begin
               w_state_nxt    = REQ;
               w_fetch_pc_nxt = r_pc + PC_INC;
            end else begin
               w_state_nxt = HOLD;
            end
         end
         default: begin
            w_state_nxt = REQ;
            w_kill_nxt  = 1'b0;
         end
      endcase

      if (redirect_i) begin
         w_fetch_pc_nxt   = {redirect_pc_i[XLEN-1:2], 2'b00};
         w_misaligned_nxt = |redirect_pc_i[1:0];
      end else begin
         w_misaligned_nxt = r_misaligned;
      end
   end

   // State and output registers; handshake outputs are decoded from the next state.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state      <= REQ;
         r_fetch_pc   <= RESET_PC;
         r_kill       <= 1'b0;
         r_req        <= 1'b0;
         r_valid      <= 1'b0;
         r_instr      <= {XLEN{1'b0}};
         r_pc         <= RESET_PC;
         r_pc_plus4   <= RESET_PC + PC_INC;
         r_misaligned <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_fetch_pc   <= w_fetch_pc_nxt;
         r_kill       <= w_kill_nxt;
         r_req        <= (w_state_nxt == REQ);
         r_valid      <= (w_state_nxt == HOLD);
         r_instr      <= w_instr_nxt;
         r_pc         <= w_pc_nxt;
         r_pc_plus4   <= w_pc_nxt + PC_INC;
         r_misaligned <= w_misaligned_nxt;
      end
   end

   assign imem_req_o    = r_req;
   assign imem_addr_o   = r_fetch_pc;
   assign instr_valid_o = r_valid;
   assign instr_o       = r_instr;
   assign instr_op_o    = r_instr[6:0];
   assign pc_o          = r_pc;
   assign pc_plus4_o    = r_pc_plus4;
   assign misaligned_o  = r_misaligned;

endmodule

// File: doc/rv_fetch.md
Name: rv_fetch

Overview:
- Instruction fetch stage for the rv_core_sc core; sits directly upstream of the control/decode stage.
- Owns the PC register and issues requests to instruction memory over a req/gnt/rvalid handshake.
- Holds one fetched instruction and presents it, together with its opcode field, to the control unit.
- Takes a PC redirect from execute for branches, JAL and JALR.

Parameters:
- XLEN, 32: width of the PC, address and instruction data.
- RESET_PC, 32'h0000_0000: PC value loaded on reset.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  synchronous active-low reset
- imem_req_o  out  1  fetch request
- imem_addr_o  out  XLEN  fetch address, always word-aligned
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  read data valid
- imem_rdata_i  in  XLEN  read data
- instr_valid_o  out  1  instr_o, instr_op_o and pc_o are valid
- instr_ready_i  in  1  core retires the presented instruction this cycle
- instr_o  out  XLEN  instruction word
- instr_op_o  out  7  instr_o[6:0], feeds control unit opcode input
- pc_o  out  XLEN  PC of presented instruction
- pc_plus4_o  out  XLEN  pc_o + 4, used for JAL/JALR link writeback
- redirect_i  in  1  taken branch/jump, one-cycle pulse
- redirect_pc_i  in  XLEN  redirect target
- misaligned_o  out  1  last redirect target had bits [1:0] != 0

Behaviour:
- Clock and reset: one clock, clk_i. rst_ni is synchronous and active-low; all state updates on the rising edge of clk_i.
- Reset values:
  - fetch_pc = RESET_PC, state = REQ
  - imem_req_o = 0, instr_valid_o = 0, instr_o = 0, pc_o = RESET_PC, misaligned_o = 0, kill = 0
  - imem_req_o first asserts in the cycle after rst_ni deasserts.
- FSM, three states:
  - REQ: imem_req_o = 1 and imem_addr_o = fetch_pc. On imem_gnt_i go to WAIT. imem_req_o and imem_addr_o stay stable until granted.
  - WAIT: imem_req_o = 0. On imem_rvalid_i with kill = 0: capture instr_o = imem_rdata_i and pc_o = fetch_pc, then go to HOLD. On imem_rvalid_i with kill = 1: drop the data, clear kill, go to REQ.
  - HOLD: instr_valid_o = 1. On instr_ready_i: fetch_pc = pc_o + 4, go to REQ, instr_valid_o = 0 next cycle.
- Minimum latency: 3 cycles from REQ entry to instr_valid_o with zero-wait memory (gnt in REQ, rvalid the next cycle).
- pc_plus4_o = pc_o + 4, modulo 2^XLEN. 32'hFFFF_FFFC wraps to 0.
- Redirect, highest priority, in any state:
  - fetch_pc = {redirect_pc_i[XLEN-1:2], 2'b00}; misaligned_o = |redirect_pc_i[1:0], held until the next redirect or reset.
  - In HOLD: instr_valid_o drops next cycle, go to REQ. A coincident instr_ready_i retires the current instruction, but the redirect target wins over pc_o + 4.
  - In REQ without gnt: address switches to the target next cycle, stay in REQ.
  - In REQ with gnt: set kill, go to WAIT.
  - In WAIT without rvalid: set kill, stay in WAIT.
  - In WAIT with rvalid in the same cycle: drop the data, go to REQ.
- At most one outstanding memory transaction. No request is issued while in WAIT or HOLD.
- Reset mid-transaction: state returns to REQ and kill clears. Any late rvalid arriving after reset in REQ is ignored; rvalid is only sampled in WAIT.

Decomposition:
- rv_pkg holds:
  - fetch_state_e (REQ, WAIT, HOLD)
  - XLEN default
  - RESET_PC default
  - opcode localparams shared with the control unit
- No sub-module. The PC adder is inline.

Test Plan:
- Reset release, zero-wait memory, instr_ready_i tied 1: addresses 0x0, 0x4, 0x8 fetched; instr_valid_o high every 3rd cycle; pc_plus4_o = 0x4 for pc 0x0.
- gnt delayed 3 cycles: imem_addr_o stays 0x0 and imem_req_o stays high throughout; exactly one transaction is issued.
- redirect_i with target 0x100 while in WAIT: returning data for 0x4 is dropped; next request is to 0x100; pc_o = 0x100.
- redirect_i with target 0x202: fetch at 0x200, misaligned_o = 1; a following redirect to 0x300 clears it.
- instr_ready_i held 0 for 5 cycles: instr_o and pc_o stable and no new imem_req_o; redirect_i together with ready in HOLD resumes at the target.
- rst_ni low during WAIT, then rvalid arrives: it is ignored; fetch restarts at RESET_PC with no instr_valid_o from stale data.
